data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Next-generation data memory for the MIPS pipelined datapath, sitting in the MEM stage.
- Parametrised byte-addressed big-endian storage supporting byte, halfword and word loads and stores, with sign or zero extension on loads.
- Registered read path with programmable access latency and a Stall handshake to the hazard unit.
- Alignment checking with an AddrError pulse for the exception logic.

Parameters:
ADDR_BITS, 16, byte-address bits actually decoded; depth = 2**ADDR_BITS bytes
LATENCY, 1, cycles from request acceptance to Ready pulse (legal range 1..15)

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
MemRead  input  1  load request (sampled in IDLE)
MemWrite  input  1  store request (sampled in IDLE); wins if both asserted
Size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
Unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend
Address  input  32  byte address; only [ADDR_BITS-1:0] used
WriteData  input  32  store data, right-justified (byte in [7:0], half in [15:0])
ReadData  output  32  extended load result, held until next completed load
Ready  output  1  one-cycle pulse: access completed
Stall  output  1  high while an accepted access is in progress (LATENCY>1)
AddrError  output  1  one-cycle pulse: misaligned request rejected

Behaviour:
- Reset (async, any time): state IDLE, counter 0, ReadData 0, Ready 0, Stall 0, AddrError 0. Memory contents not cleared. An access in flight is aborted; its pending write is dropped.
- Storage is big-endian: word at A occupies bytes A (bits 31:24), A+1, A+2, A+3 (bits 7:0). Halfword at A: A (15:8), A+1 (7:0).
- Index = Address[ADDR_BITS-1:0]. Higher address bits are ignored, so addresses alias modulo depth.
- Alignment: halfword requires Address[0]=0. Word requires Address[1:0]=00. Byte is always aligned.
- FSM states: IDLE and BUSY.
- IDLE, rising edge with MemRead|MemWrite:
  - Misaligned: AddrError=1 next cycle, no write, ReadData unchanged, Ready stays 0, remain IDLE.
  - Aligned: Address, WriteData, Size, Unsigned and op are captured. Op is write if MemWrite, otherwise read.
  - LATENCY=1: access performed at this same edge. Write commits; or ReadData loads. Ready=1 for the following cycle. Remain IDLE.
  - LATENCY>1: go to BUSY, counter=LATENCY-1, Stall=1.
- BUSY: inputs ignored. Counter decrements each edge. At the edge where counter reaches 0, the captured access is performed, Ready=1 next cycle, Stall=0, return to IDLE.
- A new request can be accepted in the cycle Ready is high, giving back-to-back throughput of 1 access per LATENCY cycles.
- Load extension:
  - byte: Unsigned ? {24'0,b} : {{24{b[7]}},b}
  - half: same rule on 16 bits
  - word: unmodified
- Stores write only the addressed bytes. Other bytes are untouched.
- Read-after-write: a load accepted after a store's Ready returns the new data.
- Ready and AddrError are never high in the same cycle.

Test Plan:
- LATENCY=1: SW 0x12345678 @0x10, then LW @0x10 -> Ready pulse one cycle after each edge; ReadData=0x12345678. LBU @0x10=0x00000012; LBU @0x13=0x00000078.
- SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80. LBU -> 0x00000080. SH 0x8001 @0x22, then LH -> 0xFFFF8001; LHU -> 0x00008001. Byte @0x20 unchanged.
- LW @0x02 and SH @0x05 -> AddrError pulses 1 cycle, Ready stays 0, memory and ReadData unchanged.
- LATENCY=3: LW accepted at edge N -> Stall=1 for cycles N..N+1, write/read at edge N+2, Ready in cycle after N+2. A second request presented during Stall is ignored.
- LATENCY=3: SW 0xDEADBEEF, Reset asserted mid-BUSY -> outputs 0 immediately. Subsequent LW returns the old contents, not 0xDEADBEEF.
- ADDR_BITS=16: SW 0xCAFEF00D @0x00010004, then LW @0x00000004 -> 0xCAFEF00D (aliasing).

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   MEM-stage data memory for the MIPS pipeline. Byte-addressed, big-endian
//   storage of 2**ADDR_BITS bytes. Handles byte/halfword/word loads and
//   stores, with sign or zero extension on loads. Each access takes LATENCY
//   cycles from acceptance to the Ready pulse. Misaligned requests are
//   rejected with a one-cycle AddrError pulse.
//
// Ports
//   Clk, Reset            clock, asynchronous active-high reset
//   MemRead, MemWrite     load / store request, sampled in IDLE (store wins)
//   Size                  00 byte, 01 half, 10/11 word
//   Unsigned              1 zero-extend loads, 0 sign-extend
//   Address               byte address, low ADDR_BITS decoded
//   WriteData             right-justified store data
//   ReadData              extended load result, held until the next load
//   Ready                 one-cycle pulse, access completed
//   Stall                 access in progress (LATENCY > 1)
//   AddrError             one-cycle pulse, misaligned request rejected
//
// State table
//   state  | meaning
//   IDLE   | accepting requests; LATENCY=1 accesses complete here
//   BUSY   | counting down a captured access; inputs ignored
module data_memory_ctrl #(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Stall,
  output logic        AddrError
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  logic [7:0] mem_q [DEPTH];

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic                 write_q;
  logic [31:0]          rdata_q;
  logic                 ready_q;
  logic                 aerr_q, aerr_d;

  logic                 req;
  logic                 misaligned;
  logic                 accept;
  logic                 do_access;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [31:0]          acc_wdata;
  logic [1:0]           acc_size;
  logic                 acc_uns;
  logic                 acc_write;
  logic [7:0]           lane_rd [4];
  logic [7:0]           lane_wr [4];
  logic [3:0]           lane_we;
  logic [31:0]          load_val;
  logic                 unused_addr;

  // Upper address bits alias and are deliberately ignored.
  assign unused_addr = ^Address;

  assign req = MemRead | MemWrite;

  always_comb begin
    case (Size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = Address[0];
      default: misaligned = |Address[1:0];
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= do_access;
      aerr_q  <= aerr_d;
      if (accept) begin
        addr_q  <= Address[ADDR_BITS-1:0];
        wdata_q <= WriteData;
        size_q  <= Size;
        uns_q   <= Unsigned;
        write_q <= MemWrite;
      end
      if (do_access && !acc_write) rdata_q <= load_val;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    aerr_d    = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (misaligned) begin
            aerr_d = 1'b1;
          end else begin
            accept = 1'b1;
            if (LATENCY == 1) begin
              do_access = 1'b1;
            end else begin
              state_d = S_BUSY;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // Counter reaches zero on this edge: perform the captured access.
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ReadData  = rdata_q;
    Ready     = ready_q;
    AddrError = aerr_q;
    Stall     = (state_q == S_BUSY);
  end

  // Single-cycle accesses use the live inputs; multi-cycle ones the capture.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = Address[ADDR_BITS-1:0];
      acc_wdata = WriteData;
      acc_size  = Size;
      acc_uns   = Unsigned;
      acc_write = MemWrite;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_write = write_q;
    end
  end

  // Lane i is byte i of the enclosing aligned word; lane 0 is the MSB.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_rd[i] = mem_q[{acc_addr[ADDR_BITS-1:2], 2'(i)}];
    end
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b        = lane_rd[acc_addr[1:0]];
    h        = acc_addr[1] ? {lane_rd[2], lane_rd[3]} : {lane_rd[0], lane_rd[1]};
    load_val = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
    case (acc_size)
      SZ_BYTE: load_val = acc_uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_val = acc_uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: ;
    endcase
  end

  always_comb begin
    lane_wr[0] = acc_wdata[31:24];
    lane_wr[1] = acc_wdata[23:16];
    lane_wr[2] = acc_wdata[15:8];
    lane_wr[3] = acc_wdata[7:0];
    lane_we    = 4'b1111;
    case (acc_size)
      SZ_BYTE: begin
        for (int i = 0; i < 4; i++) lane_wr[i] = acc_wdata[7:0];
        lane_we = 4'b0001 << acc_addr[1:0];
      end
      SZ_HALF: begin
        lane_wr[0] = acc_wdata[15:8];
        lane_wr[1] = acc_wdata[7:0];
        lane_wr[2] = acc_wdata[15:8];
        lane_wr[3] = acc_wdata[7:0];
        lane_we    = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Storage is never reset; a write in flight during reset is dropped.
  always_ff @(posedge Clk) begin
    if (do_access && acc_write && !Reset) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) mem_q[{acc_addr[ADDR_BITS-1:2], 2'(i)}] <= lane_wr[i];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: instance 0 uses LATENCY=1,
// instance 1 uses LATENCY=3. Stimulus pushes the expected response
// (kind, ReadData, completion cycle); a negedge monitor pops and compares.
module tb_data_memory_ctrl;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        mr  [2];
  logic        mw  [2];
  logic        un  [2];
  logic [1:0]  sz  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic [31:0] rd  [2];
  logic        rdy [2];
  logic        stl [2];
  logic        aer [2];
  logic [31:0] last [2];

  exp_t q0[$];
  exp_t q1[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  data_memory_ctrl #(.ADDR_BITS(16), .LATENCY(1)) dut_l1 (
    .Clk(Clk), .Reset(Reset), .MemRead(mr[0]), .MemWrite(mw[0]), .Size(sz[0]),
    .Unsigned(un[0]), .Address(ad[0]), .WriteData(wd[0]), .ReadData(rd[0]),
    .Ready(rdy[0]), .Stall(stl[0]), .AddrError(aer[0])
  );

  data_memory_ctrl #(.ADDR_BITS(16), .LATENCY(3)) dut_l3 (
    .Clk(Clk), .Reset(Reset), .MemRead(mr[1]), .MemWrite(mw[1]), .Size(sz[1]),
    .Unsigned(un[1]), .Address(ad[1]), .WriteData(wd[1]), .ReadData(rd[1]),
    .Ready(rdy[1]), .Stall(stl[1]), .AddrError(aer[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int s, input exp_t e);
    if (s == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int s);
    exp_t e;
    int   depth;
    if (rdy[s] && aer[s]) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_aerr_excl dut%0d: both high at cycle %0d", s, cyc);
    end
    if (rdy[s] || aer[s]) begin
      depth = (s == 0) ? q0.size() : q1.size();
      if (depth == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse dut%0d: ready=%0b aerr=%0b, none expected (cycle %0d)",
                 s, rdy[s], aer[s], cyc);
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("kind_aerr dut%0d", s), 32'(aer[s]), 32'(e.err));
        chk($sformatf("readdata dut%0d", s), rd[s], e.data);
        chk($sformatf("done_cycle dut%0d", s), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      mon(0);
      mon(1);
    end
  end

  task automatic op(input int s, input logic r, input logic w, input logic [1:0] z,
                    input logic u, input logic [31:0] a, input logic [31:0] d,
                    input logic err, input logic [31:0] exp_d);
    exp_t e;
    @(negedge Clk);
    mr[s] = r; mw[s] = w; sz[s] = z; un[s] = u; ad[s] = a; wd[s] = d;
    e.err  = err;
    e.data = exp_d;
    e.cyc  = cyc + ((err || s == 0) ? 1 : 3);
    push(s, e);
    @(posedge Clk);
    #1;
    mr[s] = 1'b0;
    mw[s] = 1'b0;
    // Next request lands in the Ready cycle (back-to-back throughput).
    if (s == 1 && !err) repeat (2) @(posedge Clk);
  endtask

  task automatic ld(input int s, input logic [1:0] z, input logic u,
                    input logic [31:0] a, input logic [31:0] exp_d);
    last[s] = exp_d;
    op(s, 1'b1, 1'b0, z, u, a, 32'd0, 1'b0, exp_d);
  endtask

  task automatic st(input int s, input logic [1:0] z, input logic [31:0] a, input logic [31:0] d);
    op(s, 1'b0, 1'b1, z, 1'b0, a, d, 1'b0, last[s]);
  endtask

  task automatic bad(input int s, input logic r, input logic w, input logic [1:0] z,
                     input logic [31:0] a, input logic [31:0] d);
    op(s, r, w, z, 1'b0, a, d, 1'b1, last[s]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; un[i] = 1'b0; sz[i] = 2'b00;
      ad[i] = 32'd0; wd[i] = 32'd0; last[i] = 32'd0;
    end
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_readdata dut%0d", i), rd[i], 32'd0);
      chk($sformatf("rst_ready dut%0d", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("rst_stall dut%0d", i), 32'(stl[i]), 32'd0);
      chk($sformatf("rst_aerr dut%0d", i), 32'(aer[i]), 32'd0);
    end
    Reset = 1'b0;

    // LATENCY=1: basic word/byte/half traffic, big-endian layout
    st(0, 2'b10, 32'h10, 32'h12345678);
    ld(0, 2'b10, 1'b0, 32'h10, 32'h12345678);
    ld(0, 2'b00, 1'b1, 32'h10, 32'h00000012);
    ld(0, 2'b00, 1'b1, 32'h13, 32'h00000078);
    ld(0, 2'b00, 1'b0, 32'h11, 32'h00000034);
    ld(0, 2'b01, 1'b1, 32'h12, 32'h00005678);
    st(0, 2'b10, 32'h20, 32'h11223344);
    st(0, 2'b00, 32'h21, 32'hABCDEF80);
    ld(0, 2'b00, 1'b0, 32'h21, 32'hFFFFFF80);
    ld(0, 2'b00, 1'b1, 32'h21, 32'h00000080);
    st(0, 2'b01, 32'h22, 32'h12348001);
    ld(0, 2'b01, 1'b0, 32'h22, 32'hFFFF8001);
    ld(0, 2'b01, 1'b1, 32'h22, 32'h00008001);
    ld(0, 2'b00, 1'b1, 32'h20, 32'h00000011);
    ld(0, 2'b10, 1'b0, 32'h20, 32'h11808001);

    // Misaligned requests: AddrError only, no state change
    bad(0, 1'b1, 1'b0, 2'b10, 32'h02, 32'd0);
    bad(0, 1'b0, 1'b1, 2'b01, 32'h05, 32'h0000FFFF);
    bad(0, 1'b0, 1'b1, 2'b10, 32'h12, 32'hFFFFFFFF);
    bad(0, 1'b1, 1'b0, 2'b01, 32'h11, 32'd0);
    ld(0, 2'b10, 1'b0, 32'h10, 32'h12345678);
    ld(0, 2'b11, 1'b0, 32'h20, 32'h11808001);

    // Read+write together: store wins
    op(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5A5A5, 1'b0, last[0]);
    ld(0, 2'b10, 1'b0, 32'h30, 32'hA5A5A5A5);

    // Address aliasing modulo 2**16
    st(0, 2'b10, 32'h00010004, 32'hCAFEF00D);
    ld(0, 2'b10, 1'b0, 32'h00000004, 32'hCAFEF00D);
    ld(0, 2'b01, 1'b0, 32'h04, 32'hFFFFCAFE);
    ld(0, 2'b01, 1'b1, 32'h06, 32'h0000F00D);
    ld(0, 2'b00, 1'b0, 32'h07, 32'h0000000D);

    // LATENCY=3: stall window, intruding request ignored while BUSY
    @(negedge Clk);
    mw[1] = 1'b1; mr[1] = 1'b0; sz[1] = 2'b10; ad[1] = 32'h40; wd[1] = 32'h01020304;
    e = '{1'b0, last[1], cyc + 3};
    push(1, e);
    @(posedge Clk);
    #1;
    mr[1] = 1'b1; wd[1] = 32'hFFFFFFFF;
    @(negedge Clk);
    chk("stall_cycle_n", 32'(stl[1]), 32'd1);
    @(negedge Clk);
    chk("stall_cycle_n1", 32'(stl[1]), 32'd1);
    @(negedge Clk);
    chk("stall_released", 32'(stl[1]), 32'd0);
    mr[1] = 1'b0; mw[1] = 1'b0;
    ld(1, 2'b10, 1'b0, 32'h40, 32'h01020304);
    ld(1, 2'b00, 1'b0, 32'h43, 32'h00000004);
    bad(1, 1'b1, 1'b0, 2'b01, 32'h41, 32'd0);
    ld(1, 2'b01, 1'b1, 32'h42, 32'h00000304);

    // LATENCY=3: reset mid-BUSY aborts the pending store
    @(negedge Clk);
    mw[1] = 1'b1; sz[1] = 2'b10; ad[1] = 32'h40; wd[1] = 32'hDEADBEEF;
    @(posedge Clk);
    #1;
    mw[1] = 1'b0;
    @(negedge Clk);
    chk("stall_before_reset", 32'(stl[1]), 32'd1);
    Reset = 1'b1;
    #1;
    chk("abort_readdata dut1", rd[1], 32'd0);
    chk("abort_stall dut1", 32'(stl[1]), 32'd0);
    chk("abort_ready dut1", 32'(rdy[1]), 32'd0);
    chk("abort_readdata dut0", rd[0], 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    last[0] = 32'd0;
    last[1] = 32'd0;
    ld(1, 2'b10, 1'b0, 32'h40, 32'h01020304);

    repeat (6) @(negedge Clk);
    chk("queue_drained dut0", 32'(q0.size()), 32'd0);
    chk("queue_drained dut1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
